// File: rtl/count_hours.sv
// ============================================================================
//  Module      : count_hours
//  Description : Hours stage of a BCD time-of-day clock. It holds a 24 h BCD
//                hour (00-23). In run mode it advances on the minutes carry.
//                In set mode it advances on rising edges of a manual
//                increment level. The display output is 24 h or 12 h.
//
//  Ports       : Clk        - system clock, rising edge
//                RST        - synchronous active-high reset
//                EN         - count enable (0 freezes every advance path)
//                Carry_In   - one-cycle strobe from the minutes 59->00 wrap
//                Set_EN     - 1 = manual set mode (Carry_In ignored)
//                Inc        - manual increment level, edge-detected here
//                Mode12     - display format, 0 = 24 h, 1 = 12 h
//                Hours[7:0] - BCD display hour {tens, units}
//                PM         - 1 when the internal hour is 12-23
//                Day_Pulse  - one-cycle strobe after a run-mode 23->00 wrap
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_hours #(
    parameter int RESET_HOUR = 0
) (
    input  logic       Clk,
    input  logic       RST,
    input  logic       EN,
    input  logic       Carry_In,
    input  logic       Set_EN,
    input  logic       Inc,
    input  logic       Mode12,
    output logic [7:0] Hours,
    output logic       PM,
    output logic       Day_Pulse
);

    localparam logic [1:0] c_RST_TENS  = 2'(RESET_HOUR / 10);
    localparam logic [3:0] c_RST_UNITS = 4'(RESET_HOUR % 10);

    logic [1:0] r_tens;
    logic [3:0] r_units;
    logic       r_inc_prev;
    logic       r_day_pulse;

    logic       w_run_adv;
    logic       w_set_adv;
    logic       w_at_23;
    logic [1:0] w_tens_nxt;
    logic [3:0] w_units_nxt;

    // Set mode takes precedence: a carry arriving in set mode is dropped.
    assign w_run_adv = EN & ~Set_EN & Carry_In;
    assign w_set_adv = EN &  Set_EN & Inc & ~r_inc_prev;
    assign w_at_23   = (r_tens == 2'd2) && (r_units == 4'd3);

    always_comb begin
        w_tens_nxt  = r_tens;
        w_units_nxt = r_units;
        if (w_at_23) begin
            w_tens_nxt  = 2'd0;
            w_units_nxt = 4'd0;
        end else if (r_units == 4'd9) begin
            w_tens_nxt  = r_tens + 2'd1;
            w_units_nxt = 4'd0;
        end else begin
            w_units_nxt = r_units + 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_tens      <= c_RST_TENS;
            r_units     <= c_RST_UNITS;
            // Treating Inc as already high means a level held through
            // reset release must fall and rise before it advances.
            r_inc_prev  <= 1'b1;
            r_day_pulse <= 1'b0;
        end else begin
            r_inc_prev  <= Inc;
            r_day_pulse <= w_run_adv & w_at_23;
            if (w_run_adv || w_set_adv) begin
                r_tens  <= w_tens_nxt;
                r_units <= w_units_nxt;
            end
        end
    end

    // 12 h display mapping done directly on the BCD digits:
    // 00 -> 12, 01-12 unchanged, 13-19 -> 01-07, 20/21 -> 08/09, 22/23 -> 10/11.
    always_comb begin
        Hours = {2'b00, r_tens, r_units};
        if (Mode12) begin
            if ((r_tens == 2'd0) && (r_units == 4'd0)) begin
                Hours = 8'h12;
            end else if ((r_tens == 2'd0) ||
                         ((r_tens == 2'd1) && (r_units <= 4'd2))) begin
                Hours = {2'b00, r_tens, r_units};
            end else if (r_tens == 2'd1) begin
                Hours = {4'd0, r_units - 4'd2};
            end else if (r_units <= 4'd1) begin
                Hours = {4'd0, r_units + 4'd8};
            end else begin
                Hours = {4'd1, r_units - 4'd2};
            end
        end
    end

    assign PM        = (r_tens == 2'd2) || ((r_tens == 2'd1) && (r_units >= 4'd2));
    assign Day_Pulse = r_day_pulse;

endmodule

`default_nettype wire

// File: tb/tb_count_hours.sv
// ============================================================================
//  Module      : tb_count_hours
//  Description : Self-checking bench for count_hours. A vector table covers
//                enable, set mode and carry interaction. Hand-written
//                sequences cover the full day sweep, the 12 h mapping, the
//                wrap cases and reset with Inc held high.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_hours;

    logic       Clk = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b0;
    logic       Carry_In = 1'b0;
    logic       Set_EN = 1'b0;
    logic       Inc = 1'b0;
    logic       Mode12 = 1'b0;
    logic [7:0] Hours;
    logic       PM;
    logic       Day_Pulse;
    logic [7:0] Hours_b;
    logic       PM_b;
    logic       Day_Pulse_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    count_hours #(.RESET_HOUR(0)) u_dut (
        .Clk(Clk), .RST(RST), .EN(EN), .Carry_In(Carry_In), .Set_EN(Set_EN),
        .Inc(Inc), .Mode12(Mode12), .Hours(Hours), .PM(PM), .Day_Pulse(Day_Pulse)
    );

    // Second instance with a two-digit reset hour, sharing all inputs.
    count_hours #(.RESET_HOUR(19)) u_dut_b (
        .Clk(Clk), .RST(RST), .EN(EN), .Carry_In(Carry_In), .Set_EN(Set_EN),
        .Inc(Inc), .Mode12(Mode12), .Hours(Hours_b), .PM(PM_b), .Day_Pulse(Day_Pulse_b)
    );

    typedef struct {
        logic       rst, en, ci, set, inc, m12;
        logic [7:0] hours;
        logic       pm, day;
    } vec_t;

    function automatic logic [7:0] bcd(input int h);
        return {4'(h / 10), 4'(h % 10)};
    endfunction

    function automatic logic [7:0] disp12(input int h);
        int v;
        v = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        return bcd(v);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp_v);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] h, input logic pm, input logic day);
        chk({name, ".hours"}, Hours, h);
        chk({name, ".pm"}, {7'd0, PM}, {7'd0, pm});
        chk({name, ".day"}, {7'd0, Day_Pulse}, {7'd0, day});
    endtask

    task automatic step(input logic rst, input logic en, input logic ci,
                        input logic set, input logic inc, input logic m12);
        @(negedge Clk);
        RST = rst; EN = en; Carry_In = ci; Set_EN = set; Inc = inc; Mode12 = m12;
        @(posedge Clk);
        #1;
    endtask

    vec_t tbl[11];

    initial begin
        //            rst en ci set inc m12  hours   pm    day
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 8'h00, 1'b0, 1'b0}; // reset
        tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 8'h01, 1'b0, 1'b0}; // carry
        tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 8'h02, 1'b0, 1'b0}; // carry held: 2nd advance, 12h view
        tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 8'h02, 1'b0, 1'b0}; // EN=0 carry lost
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 8'h02, 1'b0, 1'b0}; // EN=0 Inc edge lost
        tbl[5]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0, 8'h02, 1'b0, 1'b0}; // Inc still high, no edge
        tbl[6]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 8'h02, 1'b0, 1'b0}; // Inc falls
        tbl[7]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 8'h03, 1'b0, 1'b0}; // Inc edge + carry: one advance
        tbl[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 8'h03, 1'b0, 1'b0}; // held Inc, carry dropped
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 8'h03, 1'b0, 1'b0}; // carry dropped in set mode
        tbl[10] = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b1, 8'h04, 1'b0, 1'b0}; // fresh Inc edge

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].ci, tbl[i].set, tbl[i].inc, tbl[i].m12);
            chk_all($sformatf("vec%0d", i), tbl[i].hours, tbl[i].pm, tbl[i].day);
        end

        // Full day sweep in run mode, with the 12 h view checked at each hour.
        step(1, 0, 0, 0, 0, 0);
        chk_all("sweep.rst", 8'h00, 1'b0, 1'b0);
        chk("rstb.hours", Hours_b, 8'h19);
        chk("rstb.pm", {7'd0, PM_b}, 8'd1);
        Mode12 = 1'b1; #1;
        chk("m12.h00", Hours, 8'h12);
        chk("m12b.h19", Hours_b, 8'h07);
        Mode12 = 1'b0; #1;
        for (int k = 1; k <= 23; k++) begin
            step(0, 1, 1, 0, 0, 0);
            chk_all($sformatf("sweep%0d", k), bcd(k), (k >= 12), 1'b0);
            Mode12 = 1'b1; #1;
            chk($sformatf("m12.h%0d", k), Hours, disp12(k));
            chk($sformatf("m12pm.h%0d", k), {7'd0, PM}, {7'd0, logic'(k >= 12)});
            Mode12 = 1'b0; #1;
            if (k == 1) chk("b.carry", Hours_b, 8'h20);
        end
        step(0, 1, 1, 0, 0, 0);
        chk_all("sweep.wrap", 8'h00, 1'b0, 1'b1);
        step(0, 1, 0, 0, 0, 0);
        chk_all("sweep.after", 8'h00, 1'b0, 1'b0);

        // Reset on the same edge as a 23->00 carry.
        step(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 23; k++) step(0, 1, 1, 0, 0, 0);
        chk_all("midwrap.pre", 8'h23, 1'b1, 1'b0);
        step(1, 1, 1, 0, 0, 0);
        chk_all("midwrap.rst", 8'h00, 1'b0, 1'b0);
        chk("midwrap.b", Hours_b, 8'h19);
        chk("midwrap.bday", {7'd0, Day_Pulse_b}, 8'd0);
        step(0, 1, 0, 0, 0, 0);
        chk_all("midwrap.post", 8'h00, 1'b0, 1'b0);

        // Set-mode 23->00 wrap does not pulse Day_Pulse.
        for (int k = 1; k <= 23; k++) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 1, 1, 0);
        chk_all("setwrap", 8'h00, 1'b0, 1'b0);
        step(0, 1, 0, 1, 1, 0);
        chk_all("setwrap.post", 8'h00, 1'b0, 1'b0);

        // Reset with Inc held high: no advance until Inc toggles.
        step(0, 1, 1, 0, 1, 0);
        chk_all("preinc", 8'h01, 1'b0, 1'b0);
        step(1, 1, 0, 1, 1, 0);
        chk_all("rstinc", 8'h00, 1'b0, 1'b0);
        step(0, 1, 0, 1, 1, 0);
        chk_all("rstinc.hold", 8'h00, 1'b0, 1'b0);
        step(0, 1, 0, 1, 0, 0);
        chk_all("rstinc.fall", 8'h00, 1'b0, 1'b0);
        step(0, 1, 0, 1, 1, 0);
        chk_all("rstinc.rise", 8'h01, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/count_hours.md
COUNT_HOURS -- requirements
Module: count_hours

Interface
REQ-001 Parameter RESET_HOUR, default 0, meaning: hour (decimal 0-23) loaded by reset.
REQ-002 Clk  input  1  single system clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 EN  input  1  count enable; 0 freezes all advance paths.
REQ-005 Carry_In  input  1  one-cycle strobe from upstream minutes stage on 59->00 wrap.
REQ-006 Set_EN  input  1  time-set mode select; 1 = manual set, Carry_In ignored.
REQ-007 Inc  input  1  manual increment request, level signal, edge-detected internally.
REQ-008 Mode12  input  1  display format: 0 = 24 h, 1 = 12 h.
REQ-009 Hours  output  8  BCD display hour {tens[7:4], units[3:0]}.
REQ-010 PM  output  1  1 when internal hour is 12-23, independent of Mode12.
REQ-011 Day_Pulse  output  1  one-cycle strobe on run-mode 23->00 wrap.

Function
REQ-012 Internal state SHALL be a 24 h BCD pair: tens 0-2, units 0-9, legal range 00-23 only.
REQ-013 Advance SHALL be: units+1; units 9->0 with tens+1; 23->00 wraps both digits to 0.
REQ-014 Run-mode advance condition SHALL be EN=1, Set_EN=0, Carry_In=1 sampled at the edge.
REQ-015 Set-mode advance condition SHALL be EN=1, Set_EN=1, Inc=1 and inc_prev=0 at the edge.
REQ-016 inc_prev SHALL register Inc on every non-reset edge regardless of EN or Set_EN.
REQ-017 At most one advance per clock; Carry_In with Set_EN=1 is dropped, not deferred.
REQ-018 EN=0 SHALL hold the count; a Carry_In or Inc edge occurring while EN=0 is lost.
REQ-019 Day_Pulse SHALL assert for exactly the cycle after a run-mode 23->00 advance.
REQ-020 A set-mode 23->00 wrap SHALL NOT assert Day_Pulse.
REQ-021 Hours SHALL be combinational from state and Mode12; a new count is visible the cycle after its advancing edge.
REQ-022 Mode12=0: Hours = internal BCD value (00-23).
REQ-023 Mode12=1: internal 00 -> 12; 01-12 -> unchanged; 13-23 -> value minus 12 (01-11), BCD-correct.
REQ-024 Mode12 changes SHALL take effect on Hours immediately, with no state change.
REQ-025 Carry_In held high for N consecutive cycles SHALL give N advances (edge detection is upstream's responsibility).

Reset
REQ-026 RST=1 SHALL load count = BCD(RESET_HOUR), Day_Pulse=0, inc_prev=1 on the next edge.
REQ-027 RST SHALL override EN, Carry_In, Set_EN and Inc in the same cycle.
REQ-028 Inc held high through reset release SHALL NOT cause an advance until it falls and rises again.
REQ-029 Reset asserted mid-wrap (same edge as 23->00 Carry_In) SHALL yield RESET_HOUR and Day_Pulse=0.
REQ-030 RESET_HOUR outside 0-23 is illegal; the block need not define behaviour for it.

Verification
REQ-031 Reset, EN=1, Set_EN=0, 24 Carry_In strobes -> Hours 00..23 then 00; Day_Pulse high exactly one cycle after the 24th strobe.
REQ-032 Count at 09, Carry_In -> Hours=0x10; at 19 -> 0x20; PM rises on 11->12.
REQ-033 Mode12=1 sweep: internal 00,01,12,13,23 -> Hours 0x12,0x01,0x12,0x01,0x11; PM 0,0,1,1,1.
REQ-034 Set_EN=1, Inc held high 5 cycles plus Carry_In strobes -> exactly one advance; 23 + Inc edge -> 00 with Day_Pulse=0.
REQ-035 EN=0 with Carry_In and Inc edges -> count unchanged; RST with Inc=1 held -> RESET_HOUR, no advance until Inc toggles.
